// File: rtl/imm_extend_pipe.sv
// Immediate extender with a two-entry valid/ready skid buffer.
// Decodes I/S/B/J/U/Z immediates to XLEN bits and carries a sideband tag.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   valid_i/ready_o/instr_i/immsrc_i/tag_i : upstream offer
//   valid_o/ready_i/immext_o/illegal_o/tag_o : downstream result
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      instr_i,
  input  logic [2:0]       immsrc_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  immext_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  // XLEN is meant to be 32 or 64 only.
  logic [63:0]      w;
  logic [XLEN-1:0]  dimm;
  logic             dill;
  logic             s;
  logic             unused_bits;

  assign s = instr_i[31];

  // Build a 64-bit result, then keep the low XLEN bits; for
  // XLEN=32 this still sign-extends U through bit 31.
  always_comb begin
    w    = '0;
    dill = 1'b0;
    unique case (1'b1)
      (immsrc_i == 3'b000):
        w = {{52{s}}, instr_i[31:20]};
      (immsrc_i == 3'b001):
        w = {{52{s}}, instr_i[31:25], instr_i[11:7]};
      (immsrc_i == 3'b010):
        w = {{51{s}}, s, instr_i[7], instr_i[30:25],
             instr_i[11:8], 1'b0};
      (immsrc_i == 3'b011):
        w = {{43{s}}, s, instr_i[19:12], instr_i[20],
             instr_i[30:21], 1'b0};
      (immsrc_i == 3'b100):
        w = {{32{s}}, instr_i[31:12], 12'b0};
      (immsrc_i == 3'b101):
        w = {59'b0, instr_i[19:15]};
      default: begin
        w    = '0;
        dill = 1'b1;
      end
    endcase
  end

  assign dimm        = w[XLEN-1:0];
  assign unused_bits = ^{instr_i[6:0], w};

  logic             ov, sv, rdy;
  logic [XLEN-1:0]  oimm, simm;
  logic             oill, sill;
  logic [TAG_W-1:0] otag, stag;
  logic             acc, pop;

  assign acc = valid_i & rdy;
  assign pop = ov & ready_i;

  // rdy mirrors "skid empty" as its own flop so ready_o has
  // no combinational path from ready_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ov   <= 1'b0;
      sv   <= 1'b0;
      rdy  <= 1'b1;
      oimm <= '0;
      oill <= 1'b0;
      otag <= '0;
      simm <= '0;
      sill <= 1'b0;
      stag <= '0;
    end else if (pop && sv) begin
      // acc cannot fire here: rdy is low while skid is full
      oimm <= simm;
      oill <= sill;
      otag <= stag;
      sv   <= 1'b0;
      rdy  <= 1'b1;
    end else if (acc && (!ov || pop)) begin
      oimm <= dimm;
      oill <= dill;
      otag <= tag_i;
      ov   <= 1'b1;
    end else if (acc) begin
      simm <= dimm;
      sill <= dill;
      stag <= tag_i;
      sv   <= 1'b1;
      rdy  <= 1'b0;
    end else if (pop) begin
      ov   <= 1'b0;
    end
  end

  assign ready_o   = rdy;
  assign valid_o   = ov;
  assign immext_o  = oimm;
  assign illegal_o = oill;
  assign tag_o     = otag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe, run at XLEN=32 and XLEN=64
// in parallel on shared stimulus.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_i;
  logic [31:0] instr_i;
  logic [2:0]  immsrc_i;
  logic [4:0]  tag_i;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i),
    .ready_o(rdy32), .instr_i(instr_i), .immsrc_i(immsrc_i),
    .tag_i(tag_i), .valid_o(vld32), .ready_i(ready_i),
    .immext_o(imm32), .illegal_o(ill32), .tag_o(tag32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i),
    .ready_o(rdy64), .instr_i(instr_i), .immsrc_i(immsrc_i),
    .tag_i(tag_i), .valid_o(vld64), .ready_i(ready_i),
    .immext_o(imm64), .illegal_o(ill64), .tag_o(tag64)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_state(input string nm, input logic v,
                           input logic r, input logic [4:0] t);
    chk({nm, ".valid"}, {62'b0, vld32, vld64}, {62'b0, v, v});
    chk({nm, ".ready"}, {62'b0, rdy32, rdy64}, {62'b0, r, r});
    if (v) chk({nm, ".tag"}, {54'b0, tag32, tag64}, {54'b0, t, t});
  endtask

  task automatic drive(input logic v, input logic [31:0] in,
                       input logic [2:0] src, input logic [4:0] t);
    valid_i  = v;
    instr_i  = in;
    immsrc_i = src;
    tag_i    = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [4:0]  tag;
    logic [63:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{32'hFFF00093, 3'd0, 5'd1,
                64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[1]  = '{32'h80000000, 3'd2, 5'd2,
                64'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0};
    tbl[2]  = '{32'h80000000, 3'd3, 5'd3,
                64'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
    tbl[3]  = '{32'h12345037, 3'd4, 5'd4,
                64'h12345000, 64'h0000000012345000, 1'b0};
    tbl[4]  = '{32'h80000037, 3'd4, 5'd5,
                64'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    tbl[5]  = '{32'hFFFF8073, 3'd5, 5'd6,
                64'h0000001F, 64'h000000000000001F, 1'b0};
    tbl[6]  = '{32'h7FF00013, 3'd0, 5'd8,
                64'h000007FF, 64'h00000000000007FF, 1'b0};
    tbl[7]  = '{32'h00A00523, 3'd1, 5'd9,
                64'h0000000A, 64'h000000000000000A, 1'b0};
    tbl[8]  = '{32'h80000000, 3'd1, 5'd10,
                64'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0};
    tbl[9]  = '{32'h00000F80, 3'd2, 5'd11,
                64'h0000081E, 64'h000000000000081E, 1'b0};
    tbl[10] = '{32'h001FF000, 3'd3, 5'd12,
                64'h000FF800, 64'h00000000000FF800, 1'b0};
    tbl[11] = '{32'hFFFFFFFF, 3'd6, 5'd7,
                64'h0, 64'h0, 1'b1};
    tbl[12] = '{32'h12345678, 3'd7, 5'd13,
                64'h0, 64'h0, 1'b1};

    rst_i   = 1'b1;
    ready_i = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    #2;
    chk_state("rst0", 1'b0, 1'b1, 5'd0);
    chk("rst0.imm", imm64 | {32'b0, imm32}, 64'h0);
    chk("rst0.tagill", {57'b0, tag32, ill32, ill64}, 64'h0);
    tick();
    chk_state("rst1", 1'b0, 1'b1, 5'd0);
    rst_i = 1'b0;

    // streaming, one item per cycle, result one cycle after accept
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, tbl[i].instr, tbl[i].src, tbl[i].tag);
      tick();
      chk_state($sformatf("v%0d", i), 1'b1, 1'b1, tbl[i].tag);
      chk($sformatf("v%0d.imm32", i), {32'b0, imm32}, tbl[i].e32);
      chk($sformatf("v%0d.imm64", i), imm64, tbl[i].e64);
      chk($sformatf("v%0d.ill", i), {62'b0, ill32, ill64},
          {62'b0, tbl[i].ill, tbl[i].ill});
    end
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    tick();
    chk_state("drain", 1'b0, 1'b1, 5'd0);

    // backpressure: tag1 out, tag2 skid, tag3 refused
    ready_i = 1'b0;
    drive(1'b1, 32'h00100013, 3'd0, 5'd1);
    tick();
    drive(1'b1, 32'h00200013, 3'd0, 5'd2);
    tick();
    chk_state("bp.fill", 1'b1, 1'b0, 5'd1);
    drive(1'b1, 32'h00300013, 3'd0, 5'd3);
    tick();
    chk_state("bp.hold1", 1'b1, 1'b0, 5'd1);
    // late change of the offered item must not reach stored entries
    instr_i = 32'hFFF00013;
    tick();
    instr_i = 32'h00300013;
    chk_state("bp.hold2", 1'b1, 1'b0, 5'd1);
    chk("bp.hold.imm", imm64, 64'd1);
    ready_i = 1'b1;
    tick();
    chk_state("bp.rel", 1'b1, 1'b1, 5'd2);
    chk("bp.rel.imm", {32'b0, imm32}, 64'd2);
    tick();
    chk_state("bp.t3", 1'b1, 1'b1, 5'd3);
    chk("bp.t3.imm", imm64, 64'd3);
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    tick();
    chk_state("bp.empty", 1'b0, 1'b1, 5'd0);

    // async reset with both entries full
    ready_i = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0, 5'd20);
    tick();
    drive(1'b1, 32'hFFF00093, 3'd0, 5'd21);
    tick();
    chk_state("ar.full", 1'b1, 1'b0, 5'd20);
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    #2;
    rst_i = 1'b1;
    #1;
    chk_state("ar.now", 1'b0, 1'b1, 5'd0);
    chk("ar.imm", imm64 | {32'b0, imm32}, 64'h0);
    chk("ar.tag", {59'b0, tag32 | tag64}, 64'h0);
    #2;
    rst_i   = 1'b0;
    ready_i = 1'b1;
    tick();
    chk_state("ar.post1", 1'b0, 1'b1, 5'd0);
    tick();
    chk_state("ar.post2", 1'b0, 1'b1, 5'd0);

    // first edge after a mid-cycle release accepts
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    drive(1'b1, 32'h00A00523, 3'd1, 5'd9);
    tick();
    chk_state("rel.first", 1'b1, 1'b1, 5'd9);
    chk("rel.imm", {32'b0, imm32}, 64'hA);
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter XLEN, default 32, output data width; legal values 32 and 64 only.
REQ-002 Parameter TAG_W, default 5, width of the sideband tag carried with each immediate.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 valid_i  input  1  upstream offers instr_i/immsrc_i/tag_i this cycle.
REQ-006 ready_o  output  1  block can accept; transfer occurs when valid_i & ready_o.
REQ-007 instr_i  input  32  full instruction word; bits [6:0] are ignored.
REQ-008 immsrc_i  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR zimm), 110/111 reserved.
REQ-009 tag_i  input  TAG_W  opaque sideband, returned unchanged with its immediate.
REQ-010 valid_o  output  1  immext_o/illegal_o/tag_o hold a result.
REQ-011 ready_i  input  1  downstream accepts; pop occurs when valid_o & ready_i.
REQ-012 immext_o  output  XLEN  extended immediate.
REQ-013 illegal_o  output  1  result came from a reserved immsrc_i code.
REQ-014 tag_o  output  TAG_W  tag of the current result.

Function
REQ-015 I: sign-extend instr[31:20] to XLEN.
REQ-016 S: sign-extend {instr[31:25], instr[11:7]}.
REQ-017 B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
REQ-018 J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-019 U: {instr[31:12], 12'b0}; when XLEN=64, sign-extend bit 31 into bits [63:32].
REQ-020 Z: zero-extend instr[19:15].
REQ-021 Reserved codes: immext = 0 and illegal = 1; all other codes give illegal = 0.
REQ-022 Storage is a two-entry skid buffer: an output register (visible on the outputs) and a skid register.
REQ-023 ready_o is driven directly from a flop; it is high exactly when the skid register is empty.
REQ-024 Latency: an item accepted at edge N appears on the outputs after edge N when the output register is empty or popped at edge N.
REQ-025 Throughput: one item per cycle while ready_i stays high.
REQ-026 Accept with output register empty, or popped in the same cycle: the item loads the output register.
REQ-027 Accept while the output register is held (valid_o & ~ready_i): the item loads the skid register and ready_o drops after that edge.
REQ-028 Pop with the skid register full: the skid contents move to the output register, ready_o rises and the skid register empties.
REQ-029 Ordering is strictly FIFO; no item is dropped or duplicated.
REQ-030 While valid_o & ~ready_i, immext_o, illegal_o and tag_o stay stable.
REQ-031 Entry storage is capture-time: changes to instr_i/immsrc_i after the accept edge have no effect on that entry.
REQ-032 When valid_o is low, immext_o, illegal_o and tag_o retain their last values and carry no meaning.

Reset
REQ-033 While rst_i is high: valid_o=0, ready_o=1, immext_o=0, illegal_o=0, tag_o=0, skid register empty.
REQ-034 Assertion of rst_i mid-transfer discards both entries immediately without waiting for a clock edge.
REQ-035 First accept is possible on the first rising edge after rst_i deasserts.

Verification
REQ-036 XLEN=32, ready_i=1, stream I 0xFFF00093, B 0x80000000, J 0x80000000, U 0x12345037 on consecutive cycles -> 0xFFFFFFFF, 0xFFFFF000, 0xFFF00000, 0x12345000 on consecutive cycles, each one cycle after its accept, illegal_o=0.
REQ-037 XLEN=64, U 0x80000037 -> 0xFFFFFFFF80000000; Z with instr[19:15]=5'b11111 -> 0x000000000000001F.
REQ-038 Hold ready_i=0 and offer tags 1, 2, 3 back-to-back -> tag 1 on the outputs, tag 2 in skid, ready_o=0, tag 3 not accepted; release ready_i -> tags 1, 2, 3 delivered in order with no gap after refill.
REQ-039 immsrc_i=110 with instr 0xFFFFFFFF, tag 7 -> immext_o=0, illegal_o=1, tag_o=7.
REQ-040 Reset asserted between clock edges with both entries full -> valid_o=0 and ready_o=1 before the next edge, and no stale item appears after release.
